// File: rtl/blink_rate_sequencer.sv
// Purpose : LED blink controller; debounced rate buttons, bursts of toggles with dark pauses.
// Latency : button edge -> press event after 2 sync + DEBOUNCE_CYCLES samples; rate lands next cycle
//           in IDLE/PAUSE, or on the next toggle edge in RUN.
// Backpr. : none; outputs are free-running, a pending rate waits for a toggle boundary.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (release expected synchronous to clk)
//   button[3:0]   raw asynchronous rate buttons, active-high; higher index wins on a tie
//   enable        1 = run the blink sequence, 0 = LED dark and sequencer idle
//   led_out       LED drive
//   rate_sel      active rate index: 0=4Hz 1=2Hz 2=1Hz 3=0.5Hz
//   toggle_pulse  high during the cycle whose closing edge toggles led_out
//   in_pause      high while in the dark pause between bursts
module blink_rate_sequencer #(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BURST_TOGGLES   = 8,
  parameter int unsigned PAUSE_CYCLES    = 50_000_000,
  parameter int unsigned CNT_W           = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] button,
  input  logic       enable,
  output logic       led_out,
  output logic [1:0] rate_sel,
  output logic       toggle_pulse,
  output logic       in_pause
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TOG_W = (BURST_TOGGLES > 1) ? $clog2(BURST_TOGGLES + 1) : 1;

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TOG_W-1:0] BURST_LAST = TOG_W'((BURST_TOGGLES == 0) ? 0 : BURST_TOGGLES - 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HP_LAST0   = CNT_W'(CLK_HZ / 8 - 1);
  localparam logic [CNT_W-1:0] HP_LAST1   = CNT_W'(CLK_HZ / 4 - 1);
  localparam logic [CNT_W-1:0] HP_LAST2   = CNT_W'(CLK_HZ / 2 - 1);
  localparam logic [CNT_W-1:0] HP_LAST3   = CNT_W'(CLK_HZ - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       sync1, sync2;
  logic [3:0]       stable;
  logic [DB_W-1:0]  db_cnt [4];
  logic [3:0]       db_hit;
  logic [3:0]       press_evt;
  logic             press_any;
  logic [1:0]       press_idx;
  logic             pend_vld;
  logic [1:0]       pend_idx;
  logic [CNT_W-1:0] hp_cnt, pause_cnt, hp_last;
  logic [TOG_W-1:0] tog_cnt;
  logic             hp_term, pause_term, burst_end, toggle_fire;

  // Two-flop synchroniser per button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  // A press event fires in the same cycle the stable level is about to go 0->1,
  // so the request register and the stable level update on one edge.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_hit[i]    = (sync2[i] != stable[i]) && (db_cnt[i] == DB_LAST);
      press_evt[i] = db_hit[i] && sync2[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_hit[i]) begin
          db_cnt[i] <= '0;
          stable[i] <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Fixed priority: highest button index wins among simultaneous presses.
  always_comb begin
    press_any = |press_evt;
    if (press_evt[3])      press_idx = 2'd3;
    else if (press_evt[2]) press_idx = 2'd2;
    else if (press_evt[1]) press_idx = 2'd1;
    else                   press_idx = 2'd0;
  end

  always_comb begin
    hp_last = HP_LAST2;
    case (rate_sel)
      2'd0:    hp_last = HP_LAST0;
      2'd1:    hp_last = HP_LAST1;
      2'd2:    hp_last = HP_LAST2;
      default: hp_last = HP_LAST3;
    endcase
  end

  assign hp_term     = (hp_cnt == hp_last);
  assign pause_term  = (pause_cnt == PAUSE_LAST);
  assign burst_end   = (BURST_TOGGLES != 0) && (tog_cnt == BURST_LAST);
  // Dropping enable suppresses a toggle that would otherwise land this cycle.
  assign toggle_fire = (state == S_RUN) && enable && hp_term;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_RUN;
        S_RUN:   if (toggle_fire && burst_end) state_nxt = S_PAUSE;
        S_PAUSE: if (pause_term) state_nxt = S_RUN;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    toggle_pulse = toggle_fire;
    in_pause     = (state == S_PAUSE);
  end

  // Counters and LED drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_cnt    <= '0;
      pause_cnt <= '0;
      tog_cnt   <= '0;
      led_out   <= 1'b0;
    end else if (!enable || state == S_IDLE) begin
      hp_cnt    <= '0;
      pause_cnt <= '0;
      tog_cnt   <= '0;
      led_out   <= 1'b0;
    end else if (state == S_RUN) begin
      pause_cnt <= '0;
      if (hp_term) begin
        hp_cnt  <= '0;
        led_out <= ~led_out;
        if (burst_end)               tog_cnt <= '0;
        else if (BURST_TOGGLES != 0) tog_cnt <= tog_cnt + TOG_W'(1);
      end else begin
        hp_cnt <= hp_cnt + CNT_W'(1);
      end
    end else begin
      hp_cnt  <= '0;
      led_out <= 1'b0;
      if (pause_term) pause_cnt <= '0;
      else            pause_cnt <= pause_cnt + CNT_W'(1);
    end
  end

  // Rate request: in RUN it waits for a toggle edge so no runt half-period is shown;
  // a press that coincides with a toggle becomes the next pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_sel <= 2'd2;
      pend_vld <= 1'b0;
      pend_idx <= 2'd0;
    end else if (state == S_RUN) begin
      if (toggle_fire && pend_vld) rate_sel <= pend_idx;
      if (press_any) begin
        pend_vld <= 1'b1;
        pend_idx <= press_idx;
      end else if (toggle_fire) begin
        pend_vld <= 1'b0;
      end
    end else begin
      if (press_any)     rate_sel <= press_idx;
      else if (pend_vld) rate_sel <= pend_idx;
      pend_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_blink_rate_sequencer.sv
// Purpose : scoreboard bench for blink_rate_sequencer with directed, hand-timed vectors.
// Latency : expected toggles are (gap since previous toggle or enable rise, rate_sel) pairs.
// Backpr. : none; the monitor pops one entry per observed toggle_pulse.
module tb_blink_rate_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] button;
  logic       enable;
  logic       led_out;
  logic [1:0] rate_sel;
  logic       toggle_pulse;
  logic       in_pause;

  always #5 clk = ~clk;

  blink_rate_sequencer #(
    .CLK_HZ(16), .DEBOUNCE_CYCLES(4), .BURST_TOGGLES(4), .PAUSE_CYCLES(10), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .button(button), .enable(enable),
    .led_out(led_out), .rate_sel(rate_sel), .toggle_pulse(toggle_pulse), .in_pause(in_pause)
  );

  typedef struct {
    int         gap;
    logic [1:0] rate;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cur   = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input int gap, input int rate);
    exp_t e;
    e.gap  = gap;
    e.rate = 2'(rate);
    sb_q.push_back(e);
  endtask

  // Cycle c starts 1ns after its opening posedge; inputs driven here hold for cycle c.
  task automatic step_to(input int c);
    while (cur < c) begin
      @(posedge clk);
      #1;
      cur++;
    end
  endtask

  task automatic at_neg(input int c);
    step_to(c);
    @(negedge clk);
  endtask

  // Monitor: measures toggle spacing and pause length independently of the stimulus.
  int   mon_cyc = 0;
  int   ref_cyc = 0;
  int   pl      = 0;
  logic en_prev = 1'b0;
  exp_t got_e;

  initial begin
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (rst_n) begin
        if (enable && !en_prev) ref_cyc = mon_cyc;
        if (toggle_pulse) begin
          if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_toggle: toggle at monitor cycle %0d, none expected", mon_cyc);
          end else begin
            got_e = sb_q.pop_front();
            check("toggle_gap", mon_cyc - ref_cyc, got_e.gap);
            check("toggle_rate", int'(rate_sel), int'(got_e.rate));
          end
          ref_cyc = mon_cyc;
        end
        if (in_pause) begin
          pl++;
          check("pause_led_dark", int'(led_out), 0);
        end else if (pl != 0) begin
          check("pause_length", pl, 10);
          pl = 0;
        end
      end else begin
        pl = 0;
      end
      en_prev = enable;
    end
  end

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    button = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_led", int'(led_out), 0);
    check("reset_rate", int'(rate_sel), 2);
    check("reset_toggle", int'(toggle_pulse), 0);
    check("reset_pause", int'(in_pause), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cur = 0;

    // 1Hz run: toggles 8,16,24,32, pause 33..42, toggles 50,58,66
    enable = 1'b1;
    for (int i = 0; i < 4; i++) push(8, 2);
    push(18, 2);
    push(8, 2);
    push(8, 2);

    // button[0] press event lands at cycle 64 (RUN) -> pending until toggle at 66
    step_to(59);
    button = 4'b0001;
    push(2, 0);
    push(12, 0);
    push(2, 0);
    push(2, 0);
    push(2, 0);
    at_neg(65);
    check("rate_held_until_toggle", int'(rate_sel), 2);
    step_to(69);
    button = 4'b0000;

    // button[3]+button[1] together, event lands at cycle 90 inside pause 87..96
    step_to(85);
    button = 4'b1010;
    push(26, 3);
    push(16, 3);
    push(16, 3);
    push(16, 3);
    at_neg(90);
    check("rate_before_tie_press", int'(rate_sel), 0);
    at_neg(91);
    check("rate_tie_highest_wins", int'(rate_sel), 3);
    step_to(95);
    button = 4'b0000;

    // button[2] bounces, settles high at cycle 160; single event at 165 inside pause 161..170
    step_to(152); button = 4'b0100;
    step_to(154); button = 4'b0000;
    step_to(156); button = 4'b0100;
    step_to(158); button = 4'b0000;
    step_to(160); button = 4'b0100;
    push(18, 2);
    push(8, 2);
    at_neg(165);
    check("rate_before_debounce_done", int'(rate_sel), 3);
    at_neg(166);
    check("rate_after_debounce_done", int'(rate_sel), 2);
    step_to(180);
    button = 4'b0000;

    // enable falls on the third toggle cycle of a burst (194)
    step_to(194);
    enable = 1'b0;
    @(negedge clk);
    check("no_toggle_on_disable", int'(toggle_pulse), 0);
    at_neg(195);
    check("idle_led_off", int'(led_out), 0);
    check("idle_not_paused", int'(in_pause), 0);

    // re-enable: fresh burst of four, pause 230..239
    step_to(197);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) push(8, 2);

    // button[1] event at cycle 230 (first pause cycle), then reset mid-pause
    step_to(225);
    button = 4'b0010;
    at_neg(232);
    check("rate_in_pause_applied", int'(rate_sel), 1);
    check("in_pause_before_reset", int'(in_pause), 1);
    step_to(235);
    button = 4'b0000;
    rst_n  = 1'b0;
    #1;
    check("async_reset_led", int'(led_out), 0);
    check("async_reset_pause", int'(in_pause), 0);
    check("async_reset_rate", int'(rate_sel), 2);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
